// File: rtl/dsd_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsd_seq
// Function : Sequencer for a decimating FIR. It writes input samples into a
//            circular data memory and sweeps the taps once per DECIM samples.
// Revision : 1.0
// ============================================================================
module dsd_seq #(
  parameter int IN_WIDTH     = 24,
  parameter int COEFF_W      = 18,
  parameter int NCOEFFS      = 64,
  parameter int DECIM        = 4,
  parameter int MAC_LAT      = 2,
  parameter bit FIXED_COEFFS = 1'b0,
  localparam int LGN         = $clog2(NCOEFFS)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_cwr,
  input  logic [LGN-1:0] i_caddr,
  output logic           o_cack,
  output logic           o_dmem_we,
  output logic [LGN-1:0] o_dmem_waddr,
  output logic [LGN-1:0] o_dmem_raddr,
  output logic           o_cmem_we,
  output logic [LGN-1:0] o_cmem_waddr,
  output logic [LGN-1:0] o_cmem_raddr,
  output logic           o_mac_en,
  output logic           o_mac_clr,
  output logic           o_mac_last,
  output logic           o_result_stb
);

  localparam int           PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int           DW     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [LGN-1:0] C_K_LAST = LGN'(NCOEFFS - 1);
  localparam logic [PW-1:0]  C_PH_LAST = PW'(DECIM - 1);
  localparam logic [DW-1:0]  C_DR_LAST = DW'(MAC_LAT - 1);

  generate
    if (NCOEFFS < 2 || (NCOEFFS & (NCOEFFS - 1)) != 0 || DECIM < 1 ||
        MAC_LAT < 0 || IN_WIDTH < 1 || COEFF_W < 1) begin : g_bad_params
      $error("dsd_seq: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [LGN-1:0] r_wp;
  logic [LGN-1:0] r_a;
  logic [LGN-1:0] r_k;
  logic [LGN-1:0] r_dmem_raddr;
  logic [PW-1:0]  r_phase;
  logic [DW-1:0]  r_drain;
  logic           r_mac_en;
  logic           r_mac_clr;
  logic           r_mac_last;
  logic           r_result_stb;

  logic           w_idle;
  logic           w_ready;
  logic           w_accept;
  logic           w_cack;
  logic [LGN-1:0] w_k_next;

  // Coefficient writes win over samples: a pending i_cwr masks o_ready.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_ready  = w_idle && !i_cwr;
  assign w_accept = w_ready && i_valid;
  assign w_cack   = w_idle && i_cwr && !FIXED_COEFFS;
  assign w_k_next = r_k + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_wp         <= '0;
      r_a          <= '0;
      r_k          <= '0;
      r_dmem_raddr <= '0;
      r_phase      <= '0;
      r_drain      <= '0;
      r_mac_en     <= 1'b0;
      r_mac_clr    <= 1'b0;
      r_mac_last   <= 1'b0;
      r_result_stb <= 1'b0;
    end else begin
      r_mac_clr    <= 1'b0;
      r_result_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wp <= r_wp + 1'b1;
            r_a  <= r_wp;
            if (r_phase == C_PH_LAST) begin
              // Newest sample is tap 0, so the sweep starts at its address.
              r_phase      <= '0;
              r_state      <= ST_RUN;
              r_k          <= '0;
              r_dmem_raddr <= r_wp;
              r_mac_en     <= 1'b1;
              r_mac_clr    <= 1'b1;
              r_mac_last   <= 1'b0;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (r_k == C_K_LAST) begin
            r_mac_en   <= 1'b0;
            r_mac_last <= 1'b0;
            r_drain    <= '0;
            if (MAC_LAT == 0) begin
              r_state      <= ST_DONE;
              r_result_stb <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_k          <= w_k_next;
            r_dmem_raddr <= r_a - w_k_next;
            r_mac_last   <= (w_k_next == C_K_LAST);
          end
        end
        ST_DRAIN: begin
          if (r_drain == C_DR_LAST) begin
            r_state      <= ST_DONE;
            r_result_stb <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready      = w_ready;
  assign o_cack       = w_cack;
  assign o_cmem_we    = w_cack;
  assign o_cmem_waddr = i_caddr;
  assign o_dmem_we    = w_accept;
  assign o_dmem_waddr = r_wp;
  assign o_dmem_raddr = r_dmem_raddr;
  assign o_cmem_raddr = r_k;
  assign o_mac_en     = r_mac_en;
  assign o_mac_clr    = r_mac_clr;
  assign o_mac_last   = r_mac_last;
  assign o_result_stb = r_result_stb;

endmodule
`default_nettype wire

// File: tb/tb_dsd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsd_seq
// Function : Self-checking bench for dsd_seq (NCOEFFS=8, DECIM=4, MAC_LAT=2).
// Revision : 1.0
// ============================================================================
module tb_dsd_seq;

  localparam int N = 8;
  localparam int D = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       cwr = 1'b0;
  logic [2:0] caddr = '0;

  logic       o_ready, o_cack, o_dmem_we, o_cmem_we;
  logic       o_mac_en, o_mac_clr, o_mac_last, o_result_stb;
  logic [2:0] o_dmem_waddr, o_dmem_raddr, o_cmem_waddr, o_cmem_raddr;

  logic       f_ready, f_cack, f_dmem_we, f_cmem_we;
  logic       f_mac_en, f_mac_clr, f_mac_last, f_result_stb;
  logic [2:0] f_dmem_waddr, f_dmem_raddr, f_cmem_waddr, f_cmem_raddr;

  always #5 clk = ~clk;

  dsd_seq #(.NCOEFFS(N), .DECIM(D), .MAC_LAT(L), .FIXED_COEFFS(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_cwr(cwr), .i_caddr(caddr), .o_cack(o_cack),
    .o_dmem_we(o_dmem_we), .o_dmem_waddr(o_dmem_waddr), .o_dmem_raddr(o_dmem_raddr),
    .o_cmem_we(o_cmem_we), .o_cmem_waddr(o_cmem_waddr), .o_cmem_raddr(o_cmem_raddr),
    .o_mac_en(o_mac_en), .o_mac_clr(o_mac_clr), .o_mac_last(o_mac_last),
    .o_result_stb(o_result_stb)
  );

  dsd_seq #(.NCOEFFS(N), .DECIM(D), .MAC_LAT(L), .FIXED_COEFFS(1'b1)) dut_fixed (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(f_ready),
    .i_cwr(cwr), .i_caddr(caddr), .o_cack(f_cack),
    .o_dmem_we(f_dmem_we), .o_dmem_waddr(f_dmem_waddr), .o_dmem_raddr(f_dmem_raddr),
    .o_cmem_we(f_cmem_we), .o_cmem_waddr(f_cmem_waddr), .o_cmem_raddr(f_cmem_raddr),
    .o_mac_en(f_mac_en), .o_mac_clr(f_mac_clr), .o_mac_last(f_mac_last),
    .o_result_stb(f_result_stb)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: write pointer, accept count and the cycle of the last
  // decimating accept; everything else is derived from the elapsed cycles.
  int m_wp, m_cnt, m_a, m_t0;
  bit m_busy;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_wp = 0; m_cnt = 0; m_a = 0; m_t0 = 0; m_busy = 0;
  endtask

  task automatic model_step();
    int d;
    bit e_idle, e_ready, e_cack, e_dwe, e_run;
    d = cyc - m_t0;
    if (m_busy && d > N + L + 1) m_busy = 0;
    e_idle  = !m_busy;
    e_ready = e_idle && !cwr;
    e_cack  = e_idle && cwr;
    e_dwe   = e_ready && valid;
    e_run   = m_busy && d >= 1 && d <= N;
    chk("m_ready", o_ready, e_ready);
    chk("m_cack", o_cack, e_cack);
    chk("m_cmem_we", o_cmem_we, e_cack);
    if (e_cack) chk("m_cmem_waddr", o_cmem_waddr, caddr);
    chk("m_dmem_we", o_dmem_we, e_dwe);
    if (e_dwe) chk("m_dmem_waddr", o_dmem_waddr, m_wp);
    chk("m_mac_en", o_mac_en, e_run);
    chk("m_mac_clr", o_mac_clr, e_run && d == 1);
    chk("m_mac_last", o_mac_last, e_run && d == N);
    chk("m_result_stb", o_result_stb, m_busy && d == N + L + 1);
    if (e_run) begin
      chk("m_cmem_raddr", o_cmem_raddr, d - 1);
      chk("m_dmem_raddr", o_dmem_raddr, (m_a - (d - 1) + N) % N);
    end
    chk("fixed_cack", f_cack, 0);
    chk("fixed_cmem_we", f_cmem_we, 0);
    if (e_dwe) begin
      m_a  = m_wp;
      m_wp = (m_wp + 1) % N;
      m_cnt++;
      if (m_cnt % D == 0) begin
        m_busy = 1;
        m_t0   = cyc;
      end
    end
  endtask

  // One clock: inputs change just after the edge, outputs sampled mid-cycle.
  task automatic drive(input bit v, input bit cw, input int ca);
    @(posedge clk);
    #1;
    cyc++;
    valid = v;
    cwr   = cw;
    caddr = 3'(ca);
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    valid = 1'b0; cwr = 1'b0; caddr = '0;
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit v; bit cw; int ca;
    bit e_ready; bit e_cack; bit e_dwe; int e_waddr;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    int   rd_exp[8];
    int   n_stb, n_wr, waited;
    bit   got, pend, acked;
    int   pa;

    tbl[0] = '{v:0, cw:0, ca:0, e_ready:1, e_cack:0, e_dwe:0, e_waddr:0};
    tbl[1] = '{v:1, cw:0, ca:0, e_ready:1, e_cack:0, e_dwe:1, e_waddr:0};
    tbl[2] = '{v:0, cw:1, ca:5, e_ready:0, e_cack:1, e_dwe:0, e_waddr:0};
    tbl[3] = '{v:1, cw:1, ca:3, e_ready:0, e_cack:1, e_dwe:0, e_waddr:0};
    tbl[4] = '{v:1, cw:0, ca:0, e_ready:1, e_cack:0, e_dwe:1, e_waddr:1};
    tbl[5] = '{v:0, cw:0, ca:0, e_ready:1, e_cack:0, e_dwe:0, e_waddr:0};
    rd_exp = '{3, 2, 1, 0, 7, 6, 5, 4};

    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_mac_en", o_mac_en, 0);
    chk("rst_stb", o_result_stb, 0);
    chk("rst_waddr", o_dmem_waddr, 0);
    chk("rst_cack", o_cack, 0);
    rst = 1'b0;
    model_reset();

    // Idle handshake table.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].cw, tbl[i].ca);
      chk("tbl_ready", o_ready, tbl[i].e_ready);
      chk("tbl_cack", o_cack, tbl[i].e_cack);
      chk("tbl_cmem_we", o_cmem_we, tbl[i].e_cack);
      chk("tbl_dmem_we", o_dmem_we, tbl[i].e_dwe);
      if (tbl[i].e_dwe) chk("tbl_waddr", o_dmem_waddr, tbl[i].e_waddr);
      if (tbl[i].e_cack) chk("tbl_cmem_waddr", o_cmem_waddr, tbl[i].ca);
    end

    // First decimation group after reset, full timeline.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      chk("seq_dwe", o_dmem_we, 1);
      chk("seq_waddr", o_dmem_waddr, i);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0);
      chk("seq_mac_en", o_mac_en, 1);
      chk("seq_cmem_raddr", o_cmem_raddr, i);
      chk("seq_dmem_raddr", o_dmem_raddr, rd_exp[i]);
      chk("seq_clr", o_mac_clr, i == 0);
      chk("seq_last", o_mac_last, i == 7);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0);
      chk("seq_drain_en", o_mac_en, 0);
      chk("seq_drain_stb", o_result_stb, 0);
    end
    drive(0, 0, 0);
    chk("seq_stb", o_result_stb, 1);
    chk("seq_done_ready", o_ready, 0);
    drive(0, 0, 0);
    chk("seq_ready_back", o_ready, 1);

    // Twelve back-to-back groups: wrap of write and read addresses.
    do_reset();
    n_stb = 0; n_wr = 0;
    for (int i = 0; i < 180; i++) begin
      drive(1, 0, 0);
      if (o_result_stb) n_stb++;
      if (o_dmem_we) n_wr++;
      if (i == 19) chk("wrap_raddr", o_dmem_raddr, 7);
      if (i == 30) chk("wrap_waddr", o_dmem_waddr, 0);
    end
    chk("wrap_stb_count", n_stb, 12);
    chk("wrap_wr_count", n_wr, 48);

    // Coefficient write takes priority over a simultaneous sample.
    do_reset();
    drive(1, 1, 5);
    chk("pri_cack", o_cack, 1);
    chk("pri_cmem_waddr", o_cmem_waddr, 5);
    chk("pri_ready", o_ready, 0);
    drive(1, 0, 0);
    chk("pri_dwe", o_dmem_we, 1);
    chk("pri_waddr", o_dmem_waddr, 0);

    // Coefficient write held off during a sweep.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    waited = 0; got = 0;
    for (int w = 0; w < 30 && !got; w++) begin
      drive(0, 1, 2);
      if (o_cack) got = 1;
      else waited++;
    end
    chk("hold_cack_seen", got, 1);
    chk("hold_cack_wait", waited, 11);
    drive(0, 0, 0);
    chk("hold_cack_drop", o_cack, 0);

    // Reset in the third RUN cycle aborts the sweep.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    @(posedge clk);
    #1;
    cyc++;
    chk("abort_pre_en", o_mac_en, 1);
    chk("abort_pre_k", o_cmem_raddr, 2);
    rst = 1'b1;
    #1;
    chk("abort_en", o_mac_en, 0);
    chk("abort_clr", o_mac_clr, 0);
    chk("abort_last", o_mac_last, 0);
    chk("abort_stb", o_result_stb, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n_stb = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0);
      if (o_result_stb) n_stb++;
    end
    chk("abort_no_stb", n_stb, 0);
    drive(1, 0, 0);
    chk("abort_first_waddr", o_dmem_waddr, 0);
    chk("abort_first_dwe", o_dmem_we, 1);

    // Randomised traffic against the model.
    do_reset();
    pend = 0; acked = 0; pa = 0;
    for (int i = 0; i < 800; i++) begin
      if (pend && acked) pend = 0;
      else if (!pend && $urandom_range(0, 7) == 0) begin
        pend = 1;
        pa = int'($urandom_range(0, 7));
      end
      drive($urandom_range(0, 3) != 0, pend, pa);
      acked = o_cack;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsd_seq.md
DSD_SEQ -- requirements
Module: dsd_seq

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- IN_WIDTH, 24, audio sample width (informational; no sample data passes through this block)
- COEFF_W, 18, coefficient width (informational)
- NCOEFFS, 64, tap count; power of two, at least 2
- DECIM, 4, decimation ratio, at least 1
- MAC_LAT, 2, MAC pipeline depth in cycles, at least 0
- FIXED_COEFFS, 1'b0, when 1, runtime coefficient writes are disabled
- LGN (localparam), $clog2(NCOEFFS), address width
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- i_clk, in, 1, sole clock, rising edge
- i_rst, in, 1, asynchronous active-high reset
- i_valid, in, 1, input sample offered
- o_ready, out, 1, input sample accepted when i_valid && o_ready
- i_cwr, in, 1, coefficient write request; held until acknowledged
- i_caddr, in, LGN, coefficient write address
- o_cack, out, 1, coefficient write acknowledged this cycle
- o_dmem_we, out, 1, data memory write strobe
- o_dmem_waddr, out, LGN, data memory write address
- o_dmem_raddr, out, LGN, data memory tap read address
- o_cmem_we, out, 1, coefficient memory write strobe
- o_cmem_waddr, out, LGN, coefficient memory write address
- o_cmem_raddr, out, LGN, coefficient memory read address
- o_mac_en, out, 1, MAC accumulate enable
- o_mac_clr, out, 1, first tap of sweep (MAC loads instead of adds)
- o_mac_last, out, 1, last tap of sweep
- o_result_stb, out, 1, one-cycle strobe: decimated output ready

Function
REQ-003 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-004 o_ready SHALL be 1 only in IDLE with i_cwr==0.
REQ-005 o_cack and o_cmem_we SHALL be 1 only in IDLE with i_cwr==1 and FIXED_COEFFS==0.
- Coefficient write has priority over sample input.
- o_cmem_waddr SHALL equal i_caddr.
- When FIXED_COEFFS==1, o_cack and o_cmem_we SHALL be constant 0.
REQ-006 On sample accept, the block SHALL:
- assert o_dmem_we with o_dmem_waddr = wp (combinational, same cycle);
- register the accept address A = wp;
- update wp to (wp+1) mod NCOEFFS.
REQ-007 A phase counter (0..DECIM-1) SHALL increment on each accept.
- Accept at phase DECIM-1: phase returns to 0 and the FSM goes IDLE to RUN.
- Any other accept: the FSM stays in IDLE.
REQ-008 RUN SHALL last exactly NCOEFFS cycles, with tap index k = 0..NCOEFFS-1:
- o_mac_en = 1
- o_cmem_raddr = k
- o_dmem_raddr = (A - k) mod NCOEFFS
- o_mac_clr = 1 only at k=0
- o_mac_last = 1 only at k=NCOEFFS-1
REQ-009 After RUN, the FSM SHALL spend MAC_LAT cycles in DRAIN, then go to DONE.
- If MAC_LAT==0, RUN goes directly to DONE.
- o_mac_en = 0 in DRAIN.
REQ-010 DONE SHALL last one cycle with o_result_stb = 1, then return to IDLE.
REQ-011 For a decimating accept in cycle t:
- RUN occupies cycles t+1 .. t+NCOEFFS;
- o_result_stb fires at t+NCOEFFS+MAC_LAT+1;
- o_ready is earliest 1 again at t+NCOEFFS+MAC_LAT+2.
REQ-012 o_ready SHALL be 0 outside IDLE, so no dmem write occurs during a sweep.
REQ-013 wp SHALL wrap from NCOEFFS-1 to 0, and read addresses SHALL wrap modulo NCOEFFS.
REQ-014 In RUN, DRAIN and DONE, i_cwr SHALL be held off (o_cack = 0) until IDLE.
REQ-015 o_cmem_raddr and o_dmem_raddr SHALL be registered outputs; their value outside RUN is don't-care.

Reset
REQ-016 Asserting i_rst SHALL immediately, asynchronously, force:
- state = IDLE, wp = 0, phase = 0, A = 0, k = 0;
- all registered strobes to 0.
REQ-017 Reset mid-RUN or mid-DRAIN SHALL abort the sweep with no o_result_stb.
REQ-018 After release, the first sample SHALL be written to address 0.

Verification (NCOEFFS=8, DECIM=4, MAC_LAT=2, FIXED_COEFFS=0 unless noted)
REQ-019 Reset, then 4 samples accepted back-to-back at t..t+3:
- dmem waddr = 0,1,2,3;
- RUN at t+4..t+11 with o_dmem_raddr = 3,2,1,0,7,6,5,4 and o_cmem_raddr = 0..7;
- o_mac_clr at t+4, o_mac_last at t+11;
- o_result_stb at t+14, o_ready = 1 at t+15.
REQ-020 12 decimation groups (48 samples) SHALL be run:
- waddr wraps 7 to 0;
- second sweep reads 7,6,...,0;
- exactly 12 o_result_stb pulses.
REQ-021 i_cwr=1 (i_caddr=5) and i_valid=1 held together in IDLE:
- o_cack=1, o_cmem_waddr=5, o_ready=0 in the first cycle;
- sample accepted the cycle after i_cwr drops.
REQ-022 i_cwr raised during RUN: o_cack stays 0 until IDLE, then pulses one cycle; with FIXED_COEFFS=1, o_cack is never 1.
REQ-023 i_rst pulsed at the 3rd RUN cycle:
- all strobes go to 0 immediately, no o_result_stb;
- the next accepted sample is written to address 0.
